// File: rtl/test_pattern_gen.sv
// On-chip stimulus source for a combinational circuit under test: binary count or Fibonacci LFSR vectors.
// Optional response MISR enabled by defining PATGEN_MISR_EN (adds resp_data / signature ports).
module test_pattern_gen #(
  parameter int                 WIDTH        = 5,
  parameter int                 NUM_PATTERNS = 32,
  parameter int unsigned        SEED         = 32'd1,
  parameter logic [WIDTH-1:0]   TAPS         = 5'b10100,
  parameter int                 OUT_W        = 2,
  parameter int                 SIG_W        = 16,
  parameter logic [SIG_W-1:0]   SIG_TAPS     = 16'hB400
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic                                   mode,
  output logic [WIDTH-1:0]                       pat_data,
  output logic                                   pat_valid,
  input  logic                                   pat_ready,
  output logic [$clog2(NUM_PATTERNS+1)-1:0]      pat_count,
  output logic                                   busy,
`ifdef PATGEN_MISR_EN
  input  logic [OUT_W-1:0]                       resp_data,
  output logic [SIG_W-1:0]                       signature,
`endif
  output logic                                   done
);

  localparam int                 CNT_W     = $clog2(NUM_PATTERNS + 1);
  localparam logic [CNT_W-1:0]   LAST_CNT  = CNT_W'(NUM_PATTERNS);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1'b1);
  localparam logic [WIDTH-1:0]   SEED_T    = SEED[WIDTH-1:0];
  // An all-zero LFSR state never leaves zero, so a zero seed is promoted to 1.
  localparam logic [WIDTH-1:0]   LFSR_INIT = (SEED_T == {WIDTH{1'b0}}) ? WIDTH'(1'b1) : SEED_T;

  if (NUM_PATTERNS < 1 || WIDTH < 2 || SIG_W < 2 || SIG_W < OUT_W || $bits(SIG_TAPS) != SIG_W)
  begin : g_cfg_err
    $error("test_pattern_gen: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic parity_of(input logic [31:0] v);
    return ^v;
  endfunction

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], parity_of(32'(v & TAPS))};
  endfunction

  function automatic logic [WIDTH-1:0] count_next(input logic [WIDTH-1:0] v);
    return v + WIDTH'(1'b1);
  endfunction

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [WIDTH-1:0]   pat_data_q, pat_data_d;
  logic               pat_valid_q, pat_valid_d;
  logic [CNT_W-1:0]   pat_count_q, pat_count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               handshake;
  logic [CNT_W-1:0]   count_inc;
  logic [WIDTH-1:0]   gen_next;
  logic [WIDTH-1:0]   gen_init;

`ifdef PATGEN_MISR_EN
  logic [SIG_W-1:0]   sig_q, sig_d;

  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s,
                                                 input logic [OUT_W-1:0] r);
    logic [SIG_W-1:0] fb;
    fb = 0;
    for (int b = 0; b < SIG_W; b++) begin
      fb[0] = fb[0] ^ (s[b] & SIG_TAPS[b]);
    end
    return {s[SIG_W-2:0], fb[0]} ^ SIG_W'(r);
  endfunction
`endif

  assign handshake = pat_valid_q & pat_ready;
  assign count_inc = pat_count_q + CNT_ONE;
  assign gen_next  = mode_q ? lfsr_next(pat_data_q) : count_next(pat_data_q);
  assign gen_init  = mode ? LFSR_INIT : {WIDTH{1'b0}};

  // Next-state and next-output computation for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    pat_data_d  = pat_data_q;
    pat_valid_d = pat_valid_q;
    pat_count_d = pat_count_q;
    busy_d      = busy_q;
    done_d      = done_q;
`ifdef PATGEN_MISR_EN
    sig_d       = sig_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_RUN;
          mode_d      = mode;
          pat_data_d  = gen_init;
          pat_valid_d = 1'b1;
          pat_count_d = {CNT_W{1'b0}};
          busy_d      = 1'b1;
          done_d      = 1'b0;
`ifdef PATGEN_MISR_EN
          sig_d       = {SIG_W{1'b0}};
`endif
        end else begin
          state_d     = state_q;
        end
      end
      ST_RUN: begin
        // start is deliberately ignored here; only the handshake moves things.
        if (handshake) begin
          pat_count_d = count_inc;
          pat_data_d  = gen_next;
`ifdef PATGEN_MISR_EN
          sig_d       = misr_next(sig_q, resp_data);
`endif
          if (count_inc == LAST_CNT) begin
            state_d     = ST_DONE;
            pat_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end else begin
            state_d     = ST_RUN;
          end
        end else begin
          state_d     = ST_RUN;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        pat_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any run immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      pat_data_q  <= {WIDTH{1'b0}};
      pat_valid_q <= 1'b0;
      pat_count_q <= {CNT_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      pat_data_q  <= pat_data_d;
      pat_valid_q <= pat_valid_d;
      pat_count_q <= pat_count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef PATGEN_MISR_EN
  // Signature register, advanced only on accepted vectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= {SIG_W{1'b0}};
    end else begin
      sig_q <= sig_d;
    end
  end

  assign signature = sig_q;
`endif

  assign pat_data  = pat_data_q;
  assign pat_valid = pat_valid_q;
  assign pat_count = pat_count_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Randomized self-checking bench for test_pattern_gen against a sequence-level reference model.
module tb_test_pattern_gen;
  localparam int              W  = 5;
  localparam int              N  = 32;
  localparam int              CW = $clog2(N + 1);
  localparam int              OW = 2;
  localparam int              SW = 16;
  localparam logic [W-1:0]    TAPS_TB     = 5'b10100;
  localparam logic [SW-1:0]   SIG_TAPS_TB = 16'hB400;

  logic            clk = 1'b0;
  logic            rst_n, start, mode, pat_ready;
  logic [W-1:0]    pat_data, z_data;
  logic            pat_valid, z_valid, busy, z_busy, done, z_done;
  logic [CW-1:0]   pat_count, z_count;
  logic [OW-1:0]   resp_data;
`ifdef PATGEN_MISR_EN
  logic [SW-1:0]   signature, z_sig;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  bit              m_mode, m_valid, m_done;
  int              m_idx;
  logic [SW-1:0]   m_sig;
  logic [W-1:0]    obs [0:N-1];

  always #5 clk = ~clk;

  test_pattern_gen #(.WIDTH(W), .NUM_PATTERNS(N), .SEED(1), .TAPS(TAPS_TB),
                     .OUT_W(OW), .SIG_W(SW), .SIG_TAPS(SIG_TAPS_TB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .pat_data(pat_data), .pat_valid(pat_valid), .pat_ready(pat_ready),
    .pat_count(pat_count), .busy(busy),
`ifdef PATGEN_MISR_EN
    .resp_data(resp_data), .signature(signature),
`endif
    .done(done)
  );

  // Zero-seed instance: must behave identically, since seed 0 is promoted to 1.
  test_pattern_gen #(.WIDTH(W), .NUM_PATTERNS(N), .SEED(0), .TAPS(TAPS_TB),
                     .OUT_W(OW), .SIG_W(SW), .SIG_TAPS(SIG_TAPS_TB)) dut_z (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .pat_data(z_data), .pat_valid(z_valid), .pat_ready(pat_ready),
    .pat_count(z_count), .busy(z_busy),
`ifdef PATGEN_MISR_EN
    .resp_data(resp_data), .signature(z_sig),
`endif
    .done(z_done)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] v);
    logic fb;
    fb = 1'b0;
    for (int b = 0; b < W; b++) begin
      if (TAPS_TB[b] && v[b]) fb = ~fb;
    end
    return {v[W-2:0], fb};
  endfunction

  // k-th vector of a run (k counted from 0).
  function automatic logic [W-1:0] exp_vec(input bit md, input int k);
    logic [W-1:0] v;
    if (!md) return W'(k % (1 << W));
    v = 5'd1;
    for (int i = 0; i < k; i++) v = lfsr_step(v);
    return v;
  endfunction

  function automatic logic [SW-1:0] misr_model(input logic [SW-1:0] s, input logic [OW-1:0] r);
    logic [SW-1:0] t;
    t = s & SIG_TAPS_TB;
    return {s[SW-2:0], ^t} ^ SW'(r);
  endfunction

  task automatic check_state();
    check_val("valid", pat_valid, m_valid);
    check_val("busy", busy, m_valid);
    check_val("done", done, m_done);
    check_val("count", pat_count, m_idx);
    check_val("z_valid", z_valid, m_valid);
    check_val("z_count", z_count, m_idx);
    check_val("z_done", z_done, m_done);
    if (m_valid) begin
      check_val("data", pat_data, exp_vec(m_mode, m_idx));
      check_val("z_data", z_data, exp_vec(m_mode, m_idx));
      obs[m_idx] = pat_data;
    end
`ifdef PATGEN_MISR_EN
    check_val("sig", signature, m_sig);
    check_val("z_sig", z_sig, m_sig);
`endif
  endtask

  task automatic run_case(input bit md, input int ready_pct, input int start_pct);
    int cycles = 0;
    int hold = 0;
    @(negedge clk);
    mode = md; start = 1'b1;
    pat_ready = ($urandom_range(99) < ready_pct);
    resp_data = OW'($urandom);
    @(negedge clk);
    start = 1'b0; mode = ~md;
    m_mode = md; m_idx = 0; m_valid = 1'b1; m_done = 1'b0; m_sig = '0;
    while (hold < 3 && cycles < 400) begin
      check_state();
      if (m_done) hold++;
      pat_ready = ($urandom_range(99) < ready_pct);
      start     = m_valid && ($urandom_range(99) < start_pct);
      resp_data = OW'($urandom);
      @(negedge clk);
      if (m_valid && pat_ready) begin
        m_sig = misr_model(m_sig, resp_data);
        m_idx++;
        if (m_idx == N) begin
          m_valid = 1'b0;
          m_done  = 1'b1;
        end
      end
      cycles++;
    end
    start = 1'b0;
    check_val("run_timeout", cycles < 400, 1);
  endtask

  task automatic wait_count(input int target);
    int k = 0;
    while (pat_count != target && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_val("wait_count", k < 200, 1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_val("wait_done", k < 200, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; pat_ready = 1'b0; resp_data = '0;
    m_mode = 1'b0; m_valid = 1'b0; m_done = 1'b0; m_idx = 0; m_sig = '0;
    repeat (3) @(negedge clk);
    check_val("rst_data", pat_data, 0);
    check_state();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_state();

    // LFSR run with free-flowing consumer, then spot-check the known sequence.
    run_case(1'b1, 100, 0);
    check_val("lfsr_v0", obs[0], 5'b00001);
    check_val("lfsr_v1", obs[1], 5'b00010);
    check_val("lfsr_v2", obs[2], 5'b00100);
    check_val("lfsr_v3", obs[3], 5'b01001);
    check_val("lfsr_v4", obs[4], 5'b10010);
    check_val("lfsr_v5", obs[5], 5'b00101);
    check_val("lfsr_v31", obs[31], 5'b00001);

    // Counter run started from DONE.
    run_case(1'b0, 100, 0);
    check_val("cnt_v31", obs[31], 5'd31);

    // Directed backpressure on vector 5.
    @(negedge clk);
    mode = 1'b0; start = 1'b1; pat_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_count(5);
    check_val("bp_data_pre", pat_data, 5);
    pat_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_val("bp_data_hold", pat_data, 5);
      check_val("bp_count_hold", pat_count, 5);
      check_val("bp_valid_hold", pat_valid, 1);
    end
    pat_ready = 1'b1;
    @(negedge clk);
    check_val("bp_data_next", pat_data, 6);
    check_val("bp_count_next", pat_count, 6);
    wait_done();
    check_val("bp_done_count", pat_count, N);
    check_val("bp_done_valid", pat_valid, 0);

    // Randomized runs: random mode, random backpressure, stray start pulses.
    for (int r = 0; r < 6; r++) begin
      run_case(1'($urandom), 30 + 10 * r, 15);
    end

`ifdef PATGEN_MISR_EN
    @(negedge clk);
    mode = 1'b0; start = 1'b1; pat_ready = 1'b1; resp_data = 2'b01;
    @(negedge clk);
    start = 1'b0;
    check_val("misr_clear", signature, 16'h0000);
    @(negedge clk);
    check_val("misr_hs1", signature, 16'h0001);
    @(negedge clk);
    check_val("misr_hs2", signature, 16'h0003);
    wait_done();
`endif

    // Reset in the middle of a run.
    @(negedge clk);
    mode = 1'b0; start = 1'b1; pat_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_count(10);
    rst_n = 1'b0;
    #1;
    check_val("arst_data", pat_data, 0);
    check_val("arst_valid", pat_valid, 0);
    check_val("arst_count", pat_count, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_done", done, 0);
`ifdef PATGEN_MISR_EN
    check_val("arst_sig", signature, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    m_valid = 1'b0; m_done = 1'b0; m_idx = 0; m_sig = '0;
    repeat (4) begin
      @(negedge clk);
      check_state();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/test_pattern_gen.md
Name: test_pattern_gen

Overview:
- Hardware stimulus source that sits directly upstream of a combinational circuit under test (c17-class benchmark netlists).
- Replaces file-driven vector loading with on-chip generation: either an exhaustive binary count or a Fibonacci LFSR sequence.
- Presents one vector per accepted handshake until a fixed pattern count is reached, then reports done.
- Optional MISR compacts the circuit's responses into a signature for pass/fail comparison.

Parameters:
- WIDTH, 5: pattern width; equals the circuit-under-test input count.
- NUM_PATTERNS, 32: number of vectors per run; must be at least 1.
- SEED, 1: initial LFSR state, truncated to WIDTH bits.
- TAPS, 5'b10100: LFSR feedback mask, WIDTH bits.
- OUT_W, 2: response width; used only with the MISR feature.
- SIG_W, 16: signature width; must be at least OUT_W.
- SIG_TAPS, 16'hB400: MISR feedback mask, SIG_W bits.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- start, input, 1: run request, sampled in IDLE and DONE.
- mode, input, 1: pattern source; 0 = binary counter, 1 = LFSR. Latched when start is accepted.
- pat_data, output, WIDTH: current vector, drives the circuit-under-test inputs.
- pat_valid, output, 1: pat_data is valid.
- pat_ready, input, 1: consumer accepts pat_data.
- pat_count, output, $clog2(NUM_PATTERNS+1): number of accepted vectors.
- busy, output, 1: high in RUN.
- done, output, 1: high in DONE.
- resp_data, input, OUT_W: circuit response; present only with PATGEN_MISR_EN.
- signature, output, SIG_W: MISR state; present only with PATGEN_MISR_EN.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE.
  - pat_data = 0, pat_valid = 0, pat_count = 0, busy = 0, done = 0, signature = 0.
  - Mid-run reset aborts the run immediately. There is no resume.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when start = 1:
    - Latch mode and clear pat_count.
    - Load the generator: 0 in counter mode; SEED in LFSR mode, with SEED = 0 replaced by 1 to prevent lock-up.
    - pat_valid rises on the cycle after start is sampled (one-cycle latency).
  - RUN:
    - pat_valid = 1 and busy = 1.
    - A handshake occurs when pat_valid & pat_ready.
    - On a handshake: pat_count += 1 and the generator advances.
    - When pat_count reaches NUM_PATTERNS on a handshake, go to DONE; pat_valid drops the next cycle.
    - pat_data and pat_valid are held stable while pat_ready is low.
    - start is ignored in RUN.
  - DONE:
    - done = 1, pat_valid = 0.
    - pat_count and signature hold until the next accepted start.
    - start in DONE restarts the run exactly as from IDLE, and clears done in the same cycle it enters RUN.
- Counter mode: next = pat_data + 1 modulo 2^WIDTH. If NUM_PATTERNS > 2^WIDTH, the sequence wraps silently.
- LFSR mode: next = {pat_data[WIDTH-2:0], ^(pat_data & TAPS)}. With the defaults the period is 31, so the 32nd vector repeats the first.
- pat_count width holds NUM_PATTERNS exactly and never wraps within a run.

Optional Feature:
- Macro: PATGEN_MISR_EN.
- Defined:
  - resp_data and signature ports exist.
  - signature clears to 0 when start is accepted.
  - On every handshake: signature <= {signature[SIG_W-2:0], ^(signature & SIG_TAPS)} ^ zero_extend(resp_data).
  - resp_data is sampled in the same cycle as the handshake, which assumes a combinational circuit under test.
  - signature is frozen outside handshakes.
- Undefined: resp_data and signature ports are absent, with no MISR logic and no behavioural difference otherwise.

Test Plan:
- Counter run: mode = 0, pat_ready held 1, start pulse.
  - pat_data = 0..31 on 32 consecutive cycles.
  - pat_valid low the cycle after vector 31.
  - done = 1, pat_count = 32.
- LFSR run: mode = 1, SEED = 1.
  - First six vectors are 00001, 00010, 00100, 01001, 10010, 00101.
  - Vector 32 = 00001; done after 32 handshakes.
- Backpressure: pat_ready low for 3 cycles while vector 5 is presented.
  - pat_data holds 5, pat_count holds 5.
  - Vector 6 appears the cycle after pat_ready returns high.
- Seed zero and start robustness:
  - SEED = 0 in LFSR mode → first vector 00001.
  - start pulse mid-RUN → no restart, pat_count continues.
  - start in DONE → new run from vector 0.
- Reset mid-run: assert rst_n low at pat_count = 10.
  - All outputs go to 0 immediately (asynchronous).
  - After release, state is IDLE and no pat_valid appears without start.
- MISR (PATGEN_MISR_EN): resp_data = 2'b01 on two handshakes starting from signature 0 → signature 0x0001, then 0x0003.
